// File: rtl/siso_ext_interleaver.sv
// Extrinsic former + block interleaver: stores sat(llr - sys - ext_in) per block, replays it in (A*j+B) mod N order.
// Optional EXT_SCALE_EN: 0.75 scaling before saturation plus one write-path register (out_valid one cycle later).
module siso_ext_interleaver #(
    parameter int DATA_SIZE  = 10,
    parameter int INPUT_SIZE = 7,
    parameter int BLOCK_SIZE = 21,
    parameter int INTLV_A    = 5,
    parameter int INTLV_B    = 3
) (
    input  logic                         clk_p_i,
    input  logic                         reset_p_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_SIZE-1:0]  llr_i,
    input  logic signed [INPUT_SIZE-1:0] sys_i,
    input  logic signed [INPUT_SIZE-1:0] ext_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [INPUT_SIZE-1:0] ext_o,
    output logic                         out_last_o,
    output logic                         block_done_o
);
    localparam int AW = $clog2(BLOCK_SIZE);
    localparam int CW = $clog2(BLOCK_SIZE + 1);
    localparam int RW = DATA_SIZE + 2;
    localparam int PW = RW + 2;
    localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (INPUT_SIZE - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(2 ** (INPUT_SIZE - 1)));
    localparam logic [AW-1:0] LAST_WR = AW'(BLOCK_SIZE - 1);
    localparam logic [CW-1:0] LAST_RD = CW'(BLOCK_SIZE - 1);
    localparam logic [CW-1:0] N_RD    = CW'(BLOCK_SIZE);
    localparam logic [AW:0]   N_SUM   = (AW + 1)'(BLOCK_SIZE);
    localparam logic [AW:0]   A_SUM   = (AW + 1)'(INTLV_A);
    localparam logic [AW-1:0] B_ADDR  = AW'(INTLV_B);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [AW-1:0]                wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]                rd_addr_q, rd_addr_d;
    logic [CW-1:0]                rd_cnt_q, rd_cnt_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [INPUT_SIZE-1:0] ext_q, ext_d;
    logic                         last_q, last_d;
    logic                         done_q, done_d;
    logic [AW:0]                  rd_sum;
    logic signed [INPUT_SIZE-1:0] mem_q [BLOCK_SIZE];

    logic signed [RW-1:0]         raw;
    logic signed [PW-1:0]         pre;
    logic signed [INPUT_SIZE-1:0] sat;
    logic                         in_hs, in_block;
    logic                         wr_en, wr_last;
    logic [AW-1:0]                wr_addr;
    logic signed [INPUT_SIZE-1:0] wr_dat;

    // Two guard bits: |llr| + |sys| + |ext| cannot overflow DATA_SIZE+2.
    assign raw = RW'(llr_i) - RW'(sys_i) - RW'(ext_i);

`ifdef EXT_SCALE_EN
    logic signed [PW-1:0]         raw3;
    logic                         pv_q, plast_q;
    logic [AW-1:0]                pa_q;
    logic signed [INPUT_SIZE-1:0] pd_q;

    assign raw3 = (PW'(raw) <<< 1) + PW'(raw);
    assign pre  = raw3 >>> 2;

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            pv_q    <= 1'b0;
            plast_q <= 1'b0;
            pa_q    <= '0;
            pd_q    <= '0;
        end else begin
            pv_q    <= in_hs;
            plast_q <= in_hs && (wr_cnt_q == LAST_WR);
            pa_q    <= wr_cnt_q;
            pd_q    <= sat;
        end
    end

    assign wr_en    = pv_q;
    assign wr_last  = plast_q;
    assign wr_addr  = pa_q;
    assign wr_dat   = pd_q;
    // Final sample still in the pipe register: refuse input until it lands.
    assign in_block = pv_q & plast_q;
`else
    assign pre      = PW'(raw);
    assign wr_en    = in_hs;
    assign wr_last  = (wr_cnt_q == LAST_WR);
    assign wr_addr  = wr_cnt_q;
    assign wr_dat   = sat;
    assign in_block = 1'b0;
`endif

    always_comb begin
        if (pre > SAT_HI)      sat = SAT_HI[INPUT_SIZE-1:0];
        else if (pre < SAT_LO) sat = SAT_LO[INPUT_SIZE-1:0];
        else                   sat = pre[INPUT_SIZE-1:0];
    end

    assign in_ready_o = (state_q == FILL) && !in_block;
    assign in_hs      = in_valid_i && in_ready_o;

    always_ff @(posedge clk_p_i) begin
        if (wr_en) mem_q[wr_addr] <= wr_dat;
    end

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        ext_d       = ext_q;
        last_d      = last_q;
        done_d      = 1'b0;
        rd_sum      = {1'b0, rd_addr_q} + A_SUM;
        if (in_hs) wr_cnt_d = (wr_cnt_q == LAST_WR) ? '0 : wr_cnt_q + AW'(1);
        case (state_q)
            FILL: begin
                if (wr_en && wr_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid_q && out_ready_i && last_q) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    last_d      = 1'b0;
                    done_d      = 1'b1;
                    rd_cnt_d    = '0;
                    rd_addr_d   = B_ADDR;
                end else if ((!out_valid_q || out_ready_i) && (rd_cnt_q < N_RD)) begin
                    out_valid_d = 1'b1;
                    ext_d       = mem_q[rd_addr_q];
                    last_d      = (rd_cnt_q == LAST_RD);
                    rd_cnt_d    = rd_cnt_q + CW'(1);
                    rd_addr_d   = (rd_sum >= N_SUM) ? AW'(rd_sum - N_SUM) : rd_sum[AW-1:0];
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rd_addr_q   <= B_ADDR;
            out_valid_q <= 1'b0;
            ext_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            ext_q       <= ext_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign ext_o        = ext_q;
    assign out_last_o   = last_q;
    assign block_done_o = done_q;
endmodule

// File: tb/tb_siso_ext_interleaver.sv
// Scoreboard bench for siso_ext_interleaver: a block-level model predicts the interleaved extrinsic stream,
// a monitor pops and compares every output handshake, and the main thread checks reset, latency and stalls.
module tb_siso_ext_interleaver;
    localparam int DS = 10;
    localparam int IS = 7;
    localparam int N  = 21;
    localparam int A  = 5;
    localparam int B  = 3;
`ifdef EXT_SCALE_EN
    localparam int LAT   = 3;
    localparam bit SCALE = 1'b1;
`else
    localparam int LAT   = 2;
    localparam bit SCALE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DS-1:0] llr = '0;
    logic signed [IS-1:0] sys = '0;
    logic signed [IS-1:0] ext_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [IS-1:0] ext_out;
    logic                 out_last;
    logic                 block_done;

    siso_ext_interleaver #(
        .DATA_SIZE(DS), .INPUT_SIZE(IS), .BLOCK_SIZE(N), .INTLV_A(A), .INTLV_B(B)
    ) dut (
        .clk_p_i(clk), .reset_p_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .llr_i(llr), .sys_i(sys), .ext_i(ext_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ext_o(ext_out), .out_last_o(out_last), .block_done_o(block_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: extrinsic per sample, then whole-block permutation.
    function automatic int model_ext(input int l, input int s, input int e);
        int r;
        r = l - s - e;
        if (SCALE) r = (r * 3 >= 0) ? (r * 3) / 4 : -((-(r * 3) + 3) / 4);
        if (r > 2 ** (IS - 1) - 1) r = 2 ** (IS - 1) - 1;
        if (r < -(2 ** (IS - 1))) r = -(2 ** (IS - 1));
        return r;
    endfunction

    int blk[$];
    int exp_ext[$];
    bit exp_last[$];

    task automatic model_accept(input int l, input int s, input int e);
        blk.push_back(model_ext(l, s, e));
        if (blk.size() == N) begin
            for (int j = 0; j < N; j++) begin
                exp_ext.push_back(blk[(A * j + B) % N]);
                exp_last.push_back(j == N - 1);
            end
            blk.delete();
        end
    endtask

    // Monitor
    int                   out_cnt = 0;
    int                   blocks_done = 0;
    bit                   prev_stall = 1'b0;
    bit                   prev_last_hs = 1'b0;
    logic signed [IS-1:0] prev_ext = '0;
    logic                 prev_lastv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            out_cnt      = 0;
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_ext", ext_out, prev_ext);
                chk("hold_last", out_last, prev_lastv);
            end
            if (prev_last_hs || block_done) chk("block_done", block_done, prev_last_hs);
            prev_last_hs = 1'b0;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", exp_ext.size() > 0, 1);
                if (exp_ext.size() > 0) begin
                    chk("ext_o", ext_out, exp_ext.pop_front());
                    chk("out_last", out_last, exp_last.pop_front());
                end
                out_cnt++;
                if (out_last) begin
                    prev_last_hs = 1'b1;
                    out_cnt      = 0;
                    blocks_done++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_ext   = ext_out;
            prev_lastv = out_last;
        end
    end

    // Output-ready driver: manual level or random throttling.
    bit rdy_rand = 1'b0;
    bit rdy_man  = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_man;
    end

    task automatic send(input int l, input int s, input int e);
        int  n;
        bit  acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        llr      = DS'(l);
        sys      = IS'(s);
        ext_in   = IS'(e);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("in_accept", acc, 1);
        if (acc) model_accept(l, s, e);
    endtask

    task automatic send_block(input int mode, input int gap_mode);
        int l, s, e, n, g;
        for (int k = 0; k < N; k++) begin
            l = k; s = 0; e = 0;
            if (mode == 1) begin
                l = int'($urandom_range(0, 1023)) - 512;
                s = int'($urandom_range(0, 127)) - 64;
                e = int'($urandom_range(0, 127)) - 64;
            end else if (mode == 2) begin
                if (k == 0) begin l = 300;  s = -10; e = -10; end
                if (k == 1) begin l = -300; s = 10;  e = 10;  end
                if (k == 2) l = -5;
                if (k == 3) l = 40;
                if (k == 4) l = 100;
            end
            send(l, s, e);
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (k != N - 1) repeat (g) begin @(posedge clk); #1; end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("in_ready_after_last", in_ready, 0);
        end while (!out_valid && n < 10);
        chk("first_out_latency", n, LAT);
    endtask

    task automatic wait_block();
        int start, n;
        start = blocks_done;
        n     = 0;
        while (blocks_done == start && n < 400) begin @(posedge clk); #1; n++; end
        chk("block_finish", blocks_done - start, 1);
        @(posedge clk);
        #1;
        chk("sb_drained", exp_ext.size(), 0);
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while (out_cnt != target && n < 200) begin @(posedge clk); #1; n++; end
        chk("reach_out_cnt", out_cnt, target);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ext_o", ext_out, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_block_done", block_done, 0);
        blk.delete();
        exp_ext.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        apply_reset();

        // Natural-order ramp, then saturation/scaling corners.
        send_block(0, 0);
        wait_block();
        send_block(2, 0);
        wait_block();

        // Stall three cycles with sample j=4 presented.
        send_block(0, 0);
        wait_cnt(4);
        rdy_man = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_ext", ext_out, model_ext((A * 4 + B) % N, 0, 0));
            @(posedge clk);
            #1;
        end
        rdy_man = 1'b1;
        wait_block();

        // Gappy fill, then in_valid held high with junk through the drain.
        send_block(0, 1);
        begin
            int n;
            n = 0;
            in_valid = 1'b1;
            while (out_cnt < N - 1 && n < 200) begin
                llr = DS'($urandom);
                @(negedge clk);
                chk("in_ready_drain", in_ready, 0);
                @(posedge clk);
                #1;
                n++;
            end
            in_valid = 1'b0;
        end
        wait_block();

        // Reset in the middle of DRAIN, then in the middle of FILL.
        send_block(0, 0);
        wait_cnt(10);
        apply_reset();
        send_block(0, 0);
        wait_block();
        for (int k = 0; k < 7; k++) send(k + 50, 1, 2);
        apply_reset();
        send_block(0, 0);
        wait_block();

        // Random data, random gaps, random output throttling.
        rdy_rand = 1'b1;
        repeat (4) begin
            send_block(1, 2);
            wait_block();
        end
        rdy_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
